// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Direct-mapped branch target buffer. Each entry holds a valid bit, a tag and
// a frame (2-bit saturating direction counter and branch target). Fetch looks
// the table up combinationally every cycle. The resolution stage writes it
// once the real outcome of a branch is known. Two free-running 32-bit counters
// track resolved branches and mispredictions for the CPU tracker.
//
// Ports:
//   CLK          clock, rising edge
//   nRST         asynchronous active-low reset
//   lk_pc        fetch PC to look up
//   lk_hit       valid entry with matching tag for lk_pc
//   lk_taken     predicted taken (hit and counter in a taken state)
//   lk_npc       predicted next PC (stored target if taken, else lk_pc+4)
//   upd_en       a resolved branch is presented this cycle
//   upd_pc       PC of the resolved branch
//   upd_taken    actual outcome of the resolved branch
//   upd_target   resolved branch target address
//   upd_mispred  fetch mispredicted this branch (qualified by upd_en)
//   flush        synchronous invalidate of every entry
//   branch_cnt   number of resolved branches (wraps)
//   mispred_cnt  number of mispredicted branches (wraps)
// -----------------------------------------------------------------------------
package dp_types_pkg;
  // Bit 1 set means "predict taken".
  typedef enum logic [1:0] {
    NH = 2'b00,  // not taken, strong
    NS = 2'b01,  // not taken, weak
    TH = 2'b10,  // taken, weak
    TS = 2'b11   // taken, strong
  } branch_pred_state_t;

  typedef struct packed {
    branch_pred_state_t state;
    logic [31:0]        target;
  } branch_pred_frame_t;
endpackage

module branch_predictor
  import dp_types_pkg::*;
#(
  parameter int IND_W = 8,
  parameter int TAG_W = 22
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lk_pc,
  output logic        lk_hit,
  output logic        lk_taken,
  output logic [31:0] lk_npc,
  input  logic        upd_en,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  input  logic        flush,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int DEPTH = 1 << IND_W;

  logic               valid_reg [DEPTH];
  logic [TAG_W-1:0]   tag_reg   [DEPTH];
  branch_pred_frame_t frame_reg [DEPTH];

  // ---------------------------------------------------------------- lookup
  logic [IND_W-1:0]   lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  branch_pred_frame_t lk_frame;

  assign lk_idx   = lk_pc[IND_W+1:2];
  assign lk_tag   = lk_pc[31:IND_W+2];
  assign lk_frame = frame_reg[lk_idx];

  // Reads the registered contents only, so an update to the same index in
  // this cycle is not visible until the next one.
  assign lk_hit   = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && lk_frame.state[1];
  assign lk_npc   = lk_taken ? lk_frame.target : (lk_pc + 32'd4);

  // ---------------------------------------------------------------- update
  logic [IND_W-1:0]   upd_idx;
  logic [TAG_W-1:0]   upd_tag;
  branch_pred_frame_t upd_frame;
  logic               upd_hit;
  branch_pred_state_t upd_state_next;

  assign upd_idx   = upd_pc[IND_W+1:2];
  assign upd_tag   = upd_pc[31:IND_W+2];
  assign upd_frame = frame_reg[upd_idx];
  assign upd_hit   = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

  // Saturating 2-bit counter step.
  always_comb begin
    upd_state_next = upd_frame.state;
    case (upd_frame.state)
      NH:      upd_state_next = upd_taken ? NS : NH;
      NS:      upd_state_next = upd_taken ? TH : NH;
      TH:      upd_state_next = upd_taken ? TS : NS;
      TS:      upd_state_next = upd_taken ? TS : TH;
      default: upd_state_next = NH;
    endcase
  end

  // The byte-offset bits of both PCs play no part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lk_pc[1:0], upd_pc[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic sel;
      assign sel = upd_en && (upd_idx == IND_W'(gi));

      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          valid_reg[gi] <= 1'b0;
          tag_reg[gi]   <= '0;
          frame_reg[gi] <= '{state: NH, target: 32'd0};
        end else if (flush) begin
          // Flush beats a coincident update: nothing is allocated or stepped.
          valid_reg[gi] <= 1'b0;
        end else if (sel) begin
          if (upd_hit) begin
            frame_reg[gi].state <= upd_state_next;
            if (upd_taken) begin
              frame_reg[gi].target <= upd_target;
            end
          end else if (upd_taken) begin
            // Taken miss replaces whatever lived at this index.
            valid_reg[gi] <= 1'b1;
            tag_reg[gi]   <= upd_tag;
            frame_reg[gi] <= '{state: TH, target: upd_target};
          end
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- counters
  // Not cleared by flush; only reset zeroes them.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      branch_cnt  <= 32'd0;
      mispred_cnt <= 32'd0;
    end else if (upd_en) begin
      branch_cnt <= branch_cnt + 32'd1;
      if (upd_mispred) begin
        mispred_cnt <= mispred_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
//
// Directed test of branch_predictor with hand-computed expectations.
// Inputs are driven and outputs sampled on the falling edge of CLK.
// -----------------------------------------------------------------------------
module tb_branch_predictor;

  logic        CLK;
  logic        nRST;
  logic [31:0] lk_pc;
  logic        lk_hit;
  logic        lk_taken;
  logic [31:0] lk_npc;
  logic        upd_en;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispred;
  logic        flush;
  logic [31:0] branch_cnt;
  logic [31:0] mispred_cnt;

  int total_cnt = 0;
  int bad_cnt   = 0;

  branch_predictor #(.IND_W(8), .TAG_W(22)) dut (
    .CLK         (CLK),
    .nRST        (nRST),
    .lk_pc       (lk_pc),
    .lk_hit      (lk_hit),
    .lk_taken    (lk_taken),
    .lk_npc      (lk_npc),
    .upd_en      (upd_en),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .upd_mispred (upd_mispred),
    .flush       (flush),
    .branch_cnt  (branch_cnt),
    .mispred_cnt (mispred_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Look up pc and compare all three lookup outputs.
  task automatic look(input string tag, input logic [31:0] pc,
                      input logic hit, input logic taken, input logic [31:0] npc);
    lk_pc = pc;
    #1;
    check({tag, ".hit"},   {31'd0, lk_hit},   {31'd0, hit});
    check({tag, ".taken"}, {31'd0, lk_taken}, {31'd0, taken});
    check({tag, ".npc"},   lk_npc,            npc);
  endtask

  // Present one update for a single rising edge; returns on the next falling edge.
  task automatic upd(input logic [31:0] pc, input logic taken,
                     input logic [31:0] target, input logic mis);
    upd_en      = 1'b1;
    upd_pc      = pc;
    upd_taken   = taken;
    upd_target  = target;
    upd_mispred = mis;
    @(negedge CLK);
    upd_en      = 1'b0;
    upd_mispred = 1'b0;
  endtask

  initial begin
    nRST = 1'b0; lk_pc = 32'h0; upd_en = 1'b0; upd_pc = 32'h0;
    upd_taken = 1'b0; upd_target = 32'h0; upd_mispred = 1'b0; flush = 1'b0;
    #2;
    check("rst.branch_cnt",  branch_cnt,  32'd0);
    check("rst.mispred_cnt", mispred_cnt, 32'd0);
    look("rst.lk40", 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);

    look("miss40",   32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
    look("missFFFC", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    // Allocate 0x40 -> 0x10; same-cycle lookup must still miss.
    upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h10;
    look("alloc.same_cycle", 32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
    @(negedge CLK);
    upd_en = 1'b0;
    look("alloc.TH", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0010);
    check("alloc.branch_cnt", branch_cnt, 32'd1);

    // TH -> TS -> TS (saturate) -> TS
    upd(32'h40, 1'b1, 32'h10, 1'b0);
    upd(32'h40, 1'b1, 32'h10, 1'b0);
    upd(32'h40, 1'b1, 32'h10, 1'b0);
    look("TS", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0010);
    // Not-taken steps carry a bogus target that must not be stored.
    upd(32'h40, 1'b0, 32'h99, 1'b0);
    look("nt1.TH", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0010);
    upd(32'h40, 1'b0, 32'h99, 1'b0);
    look("nt2.NS", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044);
    upd(32'h40, 1'b0, 32'h99, 1'b0);
    upd(32'h40, 1'b0, 32'h99, 1'b0);
    look("nt4.NH", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044);
    // From NH one taken gives NS (still not taken), second gives TH with new target.
    upd(32'h40, 1'b1, 32'h20, 1'b0);
    look("t.NS", 32'h0000_0040, 1'b1, 1'b0, 32'h0000_0044);
    upd(32'h40, 1'b1, 32'h20, 1'b0);
    look("t.TH", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0020);
    check("seq.branch_cnt", branch_cnt, 32'd10);

    // Alias: 0x440 shares index 0x10 with 0x40.
    look("alias.miss", 32'h0000_0440, 1'b0, 1'b0, 32'h0000_0444);
    upd(32'h440, 1'b0, 32'h80, 1'b0);
    look("alias.nt.keep40", 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0020);
    upd(32'h440, 1'b1, 32'h80, 1'b0);
    look("alias.t.440", 32'h0000_0440, 1'b1, 1'b1, 32'h0000_0080);
    look("alias.t.40",  32'h0000_0040, 1'b0, 1'b0, 32'h0000_0044);
    check("alias.branch_cnt", branch_cnt, 32'd12);
    check("alias.mispred_cnt", mispred_cnt, 32'd0);

    // Reset pulse wipes entries and counters.
    nRST = 1'b0;
    #1;
    check("rst2.branch_cnt", branch_cnt, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    look("rst2.440", 32'h0000_0440, 1'b0, 1'b0, 32'h0000_0444);

    // Five updates, two mispredicted.
    upd(32'h100, 1'b1, 32'h200, 1'b1);
    upd(32'h104, 1'b0, 32'h300, 1'b0);
    upd(32'h100, 1'b1, 32'h200, 1'b0);
    upd(32'h108, 1'b1, 32'h400, 1'b1);
    upd(32'h100, 1'b0, 32'h200, 1'b0);
    check("cnt.branch_cnt",  branch_cnt,  32'd5);
    check("cnt.mispred_cnt", mispred_cnt, 32'd2);
    // 0x100: TH -> TS -> TH ; 0x104 never allocated.
    look("cnt.100", 32'h0000_0100, 1'b1, 1'b1, 32'h0000_0200);
    look("cnt.104", 32'h0000_0104, 1'b0, 1'b0, 32'h0000_0108);

    // Flush together with a taken update: flush wins, counter still counts.
    flush = 1'b1;
    upd(32'h300, 1'b1, 32'h500, 1'b0);
    flush = 1'b0;
    look("flush.100", 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0104);
    look("flush.108", 32'h0000_0108, 1'b0, 1'b0, 32'h0000_010C);
    look("flush.300", 32'h0000_0300, 1'b0, 1'b0, 32'h0000_0304);
    check("flush.branch_cnt",  branch_cnt,  32'd6);
    check("flush.mispred_cnt", mispred_cnt, 32'd2);

    // Reset asserted mid-cycle with an update pending.
    upd_en = 1'b1; upd_pc = 32'h500; upd_taken = 1'b1; upd_target = 32'h600; upd_mispred = 1'b1;
    #2;
    nRST = 1'b0;
    #1;
    check("midrst.branch_cnt",  branch_cnt,  32'd0);
    check("midrst.mispred_cnt", mispred_cnt, 32'd0);
    look("midrst.500", 32'h0000_0500, 1'b0, 1'b0, 32'h0000_0504);
    @(negedge CLK);
    upd_en = 1'b0; upd_mispred = 1'b0;
    nRST = 1'b1;
    @(negedge CLK);
    look("postrst.500", 32'h0000_0500, 1'b0, 1'b0, 32'h0000_0504);
    check("postrst.branch_cnt", branch_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Direct-mapped branch target buffer (BTB) with one 2-bit saturating direction counter per entry.
- Fetch looks it up each cycle to choose the next PC. The branch resolution stage (EX/MEM) updates it once the branch outcome is known.
- Keeps 32-bit counters of resolved branches and mispredictions for the CPU tracker.
- Entry layout is branch_pred_frame_t plus a tag and a valid bit. State encoding is branch_pred_state_t from dp_types_pkg.

Parameters:
- IND_W, 8, index width; the BTB has 2^IND_W entries. Index is pc[IND_W+1:2].
- TAG_W, 22, tag width; tag is pc[31:IND_W+2]. IND_W + TAG_W + 2 = 32 is mandatory.

Ports:
- CLK  in  1  clock; rising edge.
- nRST  in  1  asynchronous, active-low reset.
- lk_pc  in  32  PC of the instruction being fetched.
- lk_hit  out  1  lk_pc has a valid entry with a matching tag.
- lk_taken  out  1  prediction is taken (lk_hit and state[1] set).
- lk_npc  out  32  predicted next PC: stored target if lk_taken, else lk_pc+4.
- upd_en  in  1  one resolved branch this cycle (BEQ/BNE only).
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  32  branch address (baddr) of the resolved branch.
- upd_mispred  in  1  fetch mispredicted this branch; qualified by upd_en.
- flush  in  1  synchronous invalidate of all entries.
- branch_cnt  out  32  number of resolved branches.
- mispred_cnt  out  32  number of mispredicted branches.

Behaviour:
- Lookup is purely combinational from lk_pc and the stored array. There is no lookup latency.
- On a miss: lk_hit=0, lk_taken=0, lk_npc=lk_pc+4.
- lk_pc[1:0] is ignored.
- Update is written at the rising edge of CLK when upd_en=1.
  - Index and tag come from upd_pc.
  - A hit means the entry is valid and its tag equals upd_pc's tag.
- Hit, counter transition:
  - taken: NH->NS->TH->TS, saturating at TS.
  - not taken: TS->TH->NS->NH, saturating at NH.
- Hit and upd_taken=1: target is overwritten with upd_target.
- Hit and upd_taken=0: target is unchanged.
- Miss and upd_taken=1: allocate (replace) the entry. valid=1, tag=upd_pc tag, state=TH, target=upd_target.
- Miss and upd_taken=0: no array change.
- Counters:
  - branch_cnt increments by 1 on every upd_en cycle.
  - mispred_cnt increments when upd_en and upd_mispred are both 1.
  - Both wrap modulo 2^32. flush does not affect them.
- Simultaneous lookup and update to the same index: the lookup sees the pre-update contents. There is no write-through bypass.
- flush=1: all valid bits clear at the edge.
  - flush together with upd_en: flush wins for the array (no allocate, no state change).
  - The counters still count the update.
  - Lookups in the cycle after a flush miss.
- Reset (nRST=0), at any time including mid-update:
  - Immediately clears all valid bits, sets all states to NH and all targets/tags to 0.
  - Zeroes both counters.
  - lk_hit and lk_taken go to 0 combinationally; lk_npc equals lk_pc+4.
  - An update presented in the reset cycle is lost.
- Storage must be reset-clearable. At minimum, valid and state need an async reset; tag and target may be plain registers written only on allocate.

Test Plan:
- Reset, then lookups at lk_pc=0x00000040 and 0xFFFFFFFC -> lk_hit=0, lk_taken=0, lk_npc=0x00000044 / 0x00000000 (wraps).
- upd_en with upd_pc=0x40, upd_taken=1, upd_target=0x10, then lookup 0x40 next cycle -> lk_hit=1, lk_taken=1, lk_npc=0x10, state TH.
  - Same cycle lookup of 0x40 during that update -> miss.
- From TH: two taken updates -> TS. Then not-taken updates on 0x40:
  - after 1st -> lk_taken=1 (TH);
  - after 2nd -> lk_taken=0 (NS), lk_npc=0x44;
  - after 3rd and 4th -> state stays NH.
- Alias check with 0x40 allocated:
  - lookup 0x440 (same index 0x10, different tag) -> miss.
  - Not-taken update on 0x440 -> 0x40 entry unchanged.
  - Taken update on 0x440 with target 0x80 -> 0x440 hits with npc 0x80; 0x40 now misses.
- Five updates, two with upd_mispred=1 -> branch_cnt=5, mispred_cnt=2.
  - flush with upd_en in the same cycle -> all lookups miss, branch_cnt=6.
  - Assert nRST mid-cycle with upd_en high -> counters 0 immediately, no entry allocated after release.
